// File: rtl/alu_control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_sequencer_if
// Purpose  : Bundles the run/IR inputs and every Datapath control strobe
//            driven by the hardwired control sequencer.
//            master = the sequencer, slave = the Datapath side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_control_sequencer_if #(
  parameter int NREGS = 16
);
  logic              run;
  logic [31:0]       IR;
  logic              PCout;
  logic              MARin;
  logic              IncPC;
  logic              PCin;
  logic              MDMuxread;
  logic              MDRin;
  logic              MDRout;
  logic              IRin;
  logic              Yin;
  logic              Zlowin;
  logic              Zhighin;
  logic              Zlowout;
  logic              Zhighout;
  logic              HIin;
  logic              LOin;
  logic [NREGS-1:0]  Rin;
  logic [NREGS-1:0]  Rout;
  logic [12:0]       alu_sel;
  logic              busy;
  logic              done;
  logic              illegal;

  modport master (
    input  run, IR,
    output PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin,
    output Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
    output Rin, Rout, alu_sel, busy, done, illegal
  );

  modport slave (
    output run, IR,
    input  PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin,
    input  Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
    input  Rin, Rout, alu_sel, busy, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_sequencer
// Purpose  : Hardwired control unit. Fetches an instruction, then sequences
//            the execute steps of the register-register ALU instructions
//            (three-register ops, mul/div, neg/not). Strobes are decoded
//            combinationally from the state register and the IR fields.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_sequencer #(
  parameter int NREGS = 16
) (
  input  wire logic              clock,
  input  wire logic              clear,
  alu_control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  localparam logic [4:0] c_OP_ADD = 5'b00011;
  localparam logic [4:0] c_OP_SHL = 5'b01011;
  localparam logic [4:0] c_OP_DIV = 5'b01111;
  localparam logic [4:0] c_OP_MUL = 5'b10000;
  localparam logic [4:0] c_OP_NEG = 5'b10001;
  localparam logic [4:0] c_OP_NOT = 5'b10010;

  localparam logic [NREGS-1:0] c_REG_ONE = {{(NREGS-1){1'b0}}, 1'b1};

  state_t r_state;

  logic [4:0]       w_op;
  logic [3:0]       w_ra;
  logic [3:0]       w_rb;
  logic [3:0]       w_rc;
  logic             w_is_alu3;
  logic             w_is_muldiv;
  logic             w_is_unary;
  logic             w_legal;
  logic [12:0]      w_alu_hot;
  logic [NREGS-1:0] w_ra_hot;
  logic [NREGS-1:0] w_rb_hot;
  logic [NREGS-1:0] w_rc_hot;
  state_t           w_after_done;
  logic             w_unused;

  assign w_op = bus.IR[31:27];
  assign w_ra = bus.IR[26:23];
  assign w_rb = bus.IR[22:19];
  assign w_rc = bus.IR[18:15];
  assign w_unused = ^bus.IR[14:0];

  assign w_is_alu3   = (w_op >= c_OP_ADD) && (w_op <= c_OP_SHL);
  assign w_is_muldiv = (w_op == c_OP_DIV) || (w_op == c_OP_MUL);
  assign w_is_unary  = (w_op == c_OP_NEG) || (w_op == c_OP_NOT);
  assign w_legal     = w_is_alu3 || w_is_muldiv || w_is_unary;

  // add..shl occupy ALU bits 0..8; div..not sit 6 below their opcode (bits 9..12).
  always_comb begin
    w_alu_hot = 13'd0;
    if (w_is_alu3)
      w_alu_hot = 13'd1 << (w_op - c_OP_ADD);
    else if (w_is_muldiv || w_is_unary)
      w_alu_hot = 13'd1 << (w_op - 5'd6);
  end

  assign w_ra_hot = c_REG_ONE << w_ra;
  assign w_rb_hot = c_REG_ONE << w_rb;
  assign w_rc_hot = c_REG_ONE << w_rc;

  // Back-to-back instructions re-enter fetch with no idle gap while run stays high.
  assign w_after_done = bus.run ? S_T0 : S_IDLE;

  // State register: one step per clock, clear wins from any state.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= bus.run ? S_T0 : S_IDLE;
        S_T0:    r_state <= S_T1;
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= w_legal ? S_T4 : S_FAULT;
        S_T4:    r_state <= w_is_unary ? w_after_done : S_T5;
        S_T5:    r_state <= w_is_muldiv ? S_T6 : w_after_done;
        S_T6:    r_state <= w_after_done;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobe decode from state and IR; only one bus driver is raised per state.
  always_comb begin
    bus.PCout     = 1'b0;
    bus.MARin     = 1'b0;
    bus.IncPC     = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDMuxread = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zlowin    = 1'b0;
    bus.Zhighin   = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.Rin       = '0;
    bus.Rout      = '0;
    bus.alu_sel   = 13'd0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.illegal   = 1'b0;
    case (r_state)
      S_T0: begin
        bus.busy   = 1'b1;
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.busy      = 1'b1;
        bus.Zlowout   = 1'b1;
        bus.PCin      = 1'b1;
        bus.MDMuxread = 1'b1;
        bus.MDRin     = 1'b1;
      end
      S_T2: begin
        bus.busy   = 1'b1;
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        bus.busy = 1'b1;
        if (w_is_alu3) begin
          bus.Rout = w_rb_hot;
          bus.Yin  = 1'b1;
        end else if (w_is_muldiv) begin
          bus.Rout = w_ra_hot;
          bus.Yin  = 1'b1;
        end else if (w_is_unary) begin
          bus.Rout    = w_rb_hot;
          bus.alu_sel = w_alu_hot;
          bus.Zlowin  = 1'b1;
        end
      end
      S_T4: begin
        bus.busy = 1'b1;
        if (w_is_alu3) begin
          bus.Rout    = w_rc_hot;
          bus.alu_sel = w_alu_hot;
          bus.Zlowin  = 1'b1;
        end else if (w_is_muldiv) begin
          bus.Rout    = w_rb_hot;
          bus.alu_sel = w_alu_hot;
          bus.Zlowin  = 1'b1;
          bus.Zhighin = 1'b1;
        end else if (w_is_unary) begin
          bus.Zlowout = 1'b1;
          bus.Rin     = w_ra_hot;
          bus.done    = 1'b1;
        end
      end
      S_T5: begin
        bus.busy = 1'b1;
        if (w_is_alu3) begin
          bus.Zlowout = 1'b1;
          bus.Rin     = w_ra_hot;
          bus.done    = 1'b1;
        end else if (w_is_muldiv) begin
          bus.Zlowout = 1'b1;
          bus.LOin    = 1'b1;
        end
      end
      S_T6: begin
        bus.busy     = 1'b1;
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.done     = 1'b1;
      end
      S_FAULT: begin
        bus.illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_sequencer
// Purpose  : Self-checking bench. A queue-of-steps model predicts the strobe
//            vector every cycle; directed literals pin the model, then a
//            randomized run/IR/clear stream exercises the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_sequencer;

  typedef struct packed {
    logic        pcout, marin, incpc, pcin, mdmuxread, mdrin, mdrout, irin;
    logic        yin, zlowin, zhighin, zlowout, zhighout, hiin, loin;
    logic        busy, done, illegal;
    logic [12:0] alu;
    logic [15:0] rin;
    logic [15:0] rout;
  } obs_t;

  typedef struct {
    obs_t o;
    int   ph;        // fetch step 0..2, -1 for execute steps
    bit   to_fault;  // illegal-op step, machine faults afterwards
  } step_t;

  logic clk;
  logic clear;
  alu_control_sequencer_if #(.NREGS(16)) bus();

  alu_control_sequencer #(.NREGS(16)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t got;
  assign got = {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.MDMuxread,
                bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin,
                bus.Zhighin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin,
                bus.busy, bus.done, bus.illegal, bus.alu_sel, bus.Rin, bus.Rout};

  int n_cmp = 0;
  int n_bad = 0;

  // Legal opcodes listed in ALU bit order.
  logic [4:0] ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                           5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  step_t q[$];
  bit    m_fault = 0;
  bit    model_on = 0;

  task automatic chk(string name, logic [63:0] g, logic [63:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, g, e, $time);
    end
  endtask

  function automatic obs_t busy_only();
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic void push_fetch();
    step_t s;
    s.to_fault = 0;
    s.o = busy_only(); s.ph = 0;
    s.o.pcout = 1; s.o.marin = 1; s.o.incpc = 1; s.o.zlowin = 1;
    q.push_back(s);
    s.o = busy_only(); s.ph = 1;
    s.o.zlowout = 1; s.o.pcin = 1; s.o.mdmuxread = 1; s.o.mdrin = 1;
    q.push_back(s);
    s.o = busy_only(); s.ph = 2;
    s.o.mdrout = 1; s.o.irin = 1;
    q.push_back(s);
  endfunction

  function automatic void push_exec(logic [31:0] ir);
    step_t s;
    int idx;
    logic [3:0] ra, rb, rc;
    ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    idx = -1;
    for (int i = 0; i < 13; i++) if (ops[i] == ir[31:27]) idx = i;
    s.ph = -1;
    s.to_fault = 0;
    if (idx < 0) begin
      s.o = busy_only(); s.to_fault = 1;
      q.push_back(s);
    end else if (idx <= 8) begin
      s.o = busy_only(); s.o.rout = 16'h1 << rb; s.o.yin = 1;
      q.push_back(s);
      s.o = busy_only(); s.o.rout = 16'h1 << rc; s.o.alu = 13'h1 << idx; s.o.zlowin = 1;
      q.push_back(s);
      s.o = busy_only(); s.o.zlowout = 1; s.o.rin = 16'h1 << ra; s.o.done = 1;
      q.push_back(s);
    end else if (idx <= 10) begin
      s.o = busy_only(); s.o.rout = 16'h1 << ra; s.o.yin = 1;
      q.push_back(s);
      s.o = busy_only(); s.o.rout = 16'h1 << rb; s.o.alu = 13'h1 << idx;
      s.o.zlowin = 1; s.o.zhighin = 1;
      q.push_back(s);
      s.o = busy_only(); s.o.zlowout = 1; s.o.loin = 1;
      q.push_back(s);
      s.o = busy_only(); s.o.zhighout = 1; s.o.hiin = 1; s.o.done = 1;
      q.push_back(s);
    end else begin
      s.o = busy_only(); s.o.rout = 16'h1 << rb; s.o.alu = 13'h1 << idx; s.o.zlowin = 1;
      q.push_back(s);
      s.o = busy_only(); s.o.zlowout = 1; s.o.rin = 16'h1 << ra; s.o.done = 1;
      q.push_back(s);
    end
  endfunction

  function automatic obs_t exp_now();
    obs_t o;
    o = '0;
    if (q.size() > 0) o = q[0].o;
    else if (m_fault) o.illegal = 1'b1;
    return o;
  endfunction

  // Model advance: consumes the step the DUT just finished at this edge.
  step_t h;
  always @(posedge clk) begin
    model_on = 1;
    if (clear) begin
      q.delete();
      m_fault = 0;
    end else if (m_fault) begin
    end else if (q.size() == 0) begin
      if (bus.run) push_fetch();
    end else begin
      h = q.pop_front();
      if (h.ph == 2) push_exec(bus.IR);
      if (h.to_fault) m_fault = 1;
      if (h.o.done && bus.run) push_fetch();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  obs_t e_now;
  always @(negedge clk) begin
    if (model_on) begin
      e_now = exp_now();
      n_cmp++;
      if (got !== e_now) begin
        n_bad++;
        $display("FAIL model t=%0t got=%h expected=%h", $time, got, e_now);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_instr();
    logic [31:0] r;
    logic [4:0]  op;
    r = $urandom();
    if ($urandom_range(0, 15) == 0) op = 5'($urandom_range(0, 31));
    else op = ops[$urandom_range(0, 12)];
    return {op, r[26:0]};
  endfunction

  initial begin
    clear = 1'b1;
    bus.run = 1'b0;
    bus.IR = 32'h0;
    step(); step();
    look();
    chk("reset_all_zero", 64'(got), 64'd0);
    chk("reset_busy", 64'(got.busy), 64'd0);

    // add R1 = R2 + R3, followed back-to-back by mul
    step(); clear = 1'b0; bus.run = 1'b1;
    look();
    chk("idle_before_run", 64'(got), 64'd0);
    step(); look();
    chk("add_T0_strobes", 64'({got.pcout, got.marin, got.incpc, got.pcin, got.zlowin}), 64'b11101);
    step(); look();
    chk("add_T1_strobes", 64'({got.zlowout, got.pcin, got.mdmuxread, got.mdrin, got.pcout}), 64'b11110);
    step(); bus.IR = 32'h18918000; look();
    chk("add_T2_strobes", 64'({got.mdrout, got.irin}), 64'b11);
    step(); look();
    chk("add_T3_rout", 64'(got.rout), 64'h0004);
    chk("add_T3_yin", 64'(got.yin), 64'd1);
    step(); look();
    chk("add_T4_rout", 64'(got.rout), 64'h0008);
    chk("add_T4_alu", 64'(got.alu), 64'h0001);
    chk("add_T4_zlowin", 64'(got.zlowin), 64'd1);
    step(); look();
    chk("add_T5_rin", 64'(got.rin), 64'h0002);
    chk("add_T5_zlowout_done", 64'({got.zlowout, got.done, |got.rout}), 64'b110);
    step(); look();
    chk("b2b_T0_pcout", 64'({got.pcout, got.busy, got.done}), 64'b110);

    step(); step(); bus.IR = 32'h80900000;
    step(); look();
    chk("mul_T3_rout", 64'(got.rout), 64'h0002);
    chk("mul_T3_yin", 64'(got.yin), 64'd1);
    step(); look();
    chk("mul_T4_rout", 64'(got.rout), 64'h0004);
    chk("mul_T4_alu", 64'(got.alu), 64'h0400);
    chk("mul_T4_zin", 64'({got.zlowin, got.zhighin}), 64'b11);
    step(); look();
    chk("mul_T5", 64'({got.zlowout, got.loin, got.done}), 64'b110);
    step(); look();
    chk("mul_T6", 64'({got.zhighout, got.hiin, got.done}), 64'b111);

    // neg R1 = -R2, run dropped in the final step
    step(); step(); step(); bus.IR = 32'h88900000;
    step(); look();
    chk("neg_T3_rout", 64'(got.rout), 64'h0004);
    chk("neg_T3_alu", 64'(got.alu), 64'h0800);
    chk("neg_T3_zlowin", 64'(got.zlowin), 64'd1);
    step(); bus.run = 1'b0; look();
    chk("neg_T4_rin", 64'(got.rin), 64'h0002);
    chk("neg_T4_done", 64'({got.zlowout, got.done}), 64'b11);
    step(); look();
    chk("neg_then_idle", 64'(got), 64'd0);

    // illegal opcode -> FAULT until clear
    bus.run = 1'b1;
    step(); step(); step(); bus.IR = 32'hF8000000;
    step(); look();
    chk("ill_T3_busy_only", 64'(got), 64'(busy_only()));
    step(); look();
    chk("fault_illegal", 64'({got.illegal, got.busy}), 64'b10);
    for (int i = 0; i < 4; i++) begin
      step(); bus.run = ~bus.run; look();
      chk("fault_hold", 64'({got.illegal, got.busy, got.done}), 64'b100);
    end
    step(); clear = 1'b1;
    step(); clear = 1'b0; bus.run = 1'b0; look();
    chk("fault_cleared", 64'(got), 64'd0);

    // clear in T4 of add aborts before Rin
    bus.run = 1'b1;
    step(); step(); step(); bus.IR = 32'h18918000;
    step(); look();
    chk("abort_T3_rin", 64'(got.rin), 64'd0);
    step(); clear = 1'b1; look();
    chk("abort_T4_rin", 64'(got.rin), 64'd0);
    step(); clear = 1'b0; bus.run = 1'b0; look();
    chk("abort_idle", 64'({got.busy, got.rin}), 64'd0);

    // randomized run/IR/clear stream
    for (int c = 0; c < 4000; c++) begin
      step();
      clear = ($urandom_range(0, 99) < (m_fault ? 15 : 1));
      bus.run = ($urandom_range(0, 99) < 75);
      if (q.size() > 0 && q[0].ph == 2) bus.IR = pick_instr();
      else if (q.size() == 0 || q[0].ph >= 0) bus.IR = $urandom();
    end
    step(); clear = 1'b1; bus.run = 1'b0;
    step(); step();
    look();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Hardwired control unit that drives the Datapath control strobes, so a bench no longer has to sequence them by hand.
- Fetches an instruction, then sequences the execute steps for the register-register ALU instructions, including mul/div and neg/not.
- Sits beside Datapath: it consumes the IR contents and produces every Rin/Rout, bus-select, load and ALU strobe.

Parameters:
NREGS, 16, number of general registers; sets the Rin/Rout width.

Ports:
clock  in  1  system clock; all state changes on the rising edge
clear  in  1  synchronous, active-high reset
run  in  1  level; start or continue instruction execution
IR  in  32  instruction register contents from Datapath
PCout, MARin, IncPC, PCin  out  1 each  fetch strobes
MDMuxread, MDRin, MDRout, IRin  out  1 each  memory-data and IR strobes
Yin  out  1  Y register load
Zlowin, Zhighin, Zlowout, Zhighout  out  1 each  Z register load and drive
HIin, LOin  out  1 each  HI/LO register load
Rin  out  NREGS  one-hot general-register load
Rout  out  NREGS  one-hot general-register drive
alu_sel  out  13  one-hot ALU op. Bit order [0..12]: ADD SUB AND OR ROR ROL SHR SHRA SHL DIV MUL NEG NOT
busy  out  1  high in any state other than IDLE and FAULT
done  out  1  one-cycle pulse in the final execute step
illegal  out  1  high while in FAULT

Behaviour:
- Reset: clear sampled high at a rising edge forces state IDLE, including mid-instruction. In IDLE all outputs are 0.
- Outputs are decoded combinationally from the state register and IR. No output glitches are allowed to last across an edge.
- IR field decode:
  - op = IR[31:27]
  - Ra = IR[26:23]
  - Rb = IR[22:19]
  - Rc = IR[18:15]
- Register-field to one-hot mapping: Rin/Rout bit k is set for field value k.
- Opcodes:
  - add 00011, sub 00100, and 00101, or 00110
  - ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - div 01111, mul 10000, neg 10001, not 10010
  - All other opcodes are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT. State advances one step per clock.
- IDLE: stay while run=0. Go to T0 when run=1.
- Fetch steps (all instructions):
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, MDMuxread, MDRin.
  - T2: MDRout, IRin. IR is valid from T3 onward.
- T3 with an illegal op: go to FAULT. FAULT asserts illegal only and holds until clear.
- Three-register ops (add..shl):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], alu_sel[op], Zlowin.
  - T5: Zlowout, Rin[Ra], done.
- mul/div:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], alu_sel[op], Zlowin, Zhighin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, done.
- neg/not:
  - T3: Rout[Rb], alu_sel[op], Zlowin.
  - T4: Zlowout, Rin[Ra], done.
- After the done step: go to T0 if run=1, else IDLE. There is no idle gap between back-to-back instructions.
- run deasserting mid-instruction has no effect; the current instruction completes.
- Ra=Rb or Rb=Rc is legal. Rin and Rout are never asserted in the same state.
- At most one bus driver is asserted in any state (Rout bits, PCout, MDRout, Zlowout, Zhighout).

Test Plan:
- Reset: clear=1 for 2 cycles, run=0 -> every output 0, busy=0, state IDLE.
- add: run=1, IR=0x18918000 from T3 on -> cycle trace:
  - T0: PCout/MARin/IncPC/Zlowin.
  - T1: Zlowout/PCin/MDMuxread/MDRin.
  - T2: MDRout/IRin.
  - T3: Rout=0x0004, Yin.
  - T4: Rout=0x0008, alu_sel=0x0001, Zlowin.
  - T5: Zlowout, Rin=0x0002, done.
  - Paired with Datapath, R2=0x12 and R3=0x14 give R1=0x26.
- mul: IR=0x80900000 ->
  - T3: Rout=0x0002, Yin.
  - T4: Rout=0x0004, alu_sel bit10, Zlowin+Zhighin.
  - T5: Zlowout+LOin.
  - T6: Zhighout+HIin+done.
- neg: IR=0x88900000 ->
  - T3: Rout=0x0004, alu_sel bit11, Zlowin.
  - T4: Zlowout, Rin=0x0002, done.
  - run=0 at T4 -> IDLE next cycle.
- Illegal: IR=0xF8000000 -> FAULT after T3; illegal=1 holds with run toggling; clear -> IDLE.
- Abort and back-to-back:
  - clear=1 during T4 of add -> IDLE next edge; Rin never asserted.
  - run held high -> T0 immediately follows the done cycle.
